// File: rtl/exp_arbiter.sv
// Exception request arbiter: edge-captures raw sources into sticky pending bits, picks the
// highest-priority eligible request and sequences a take / service / return cycle for CP0.
module exp_arbiter #(
  parameter int unsigned NUM_SRC      = 3,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] exp_src,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               exp_block,
  input  logic               is_eret,
  output logic               take,
  output logic [31:0]        vector,
  output logic               in_service,
  output logic [4:0]         active_id,
  output logic [31:0]        cause,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    StIdle,
    StTake,
    StService
  } state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] eret_clr;
  logic               any_eligible;
  logic               eret_done;
  logic [4:0]         winner;
  logic [31:0]        winner_cause;

  logic               take_q;
  logic               in_service_q;
  logic [31:0]        vector_q;
  logic [31:0]        cause_q;
  logic [4:0]         active_id_q;

  always_comb begin
    edge_det     = exp_src & ~src_prev_q;
    eligible     = pending_q & ~mask;
    any_eligible = |eligible;

    // Scan from the top so the lowest eligible index wins.
    winner = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 5'(i);
      end
    end
    winner_cause = (32'd1 << (winner + 5'd1)) - 32'd1;

    eret_done = (state_q == StService) && is_eret;
    eret_clr  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      eret_clr[i] = eret_done && (active_id_q == 5'(i));
    end

    // A new edge on the bit being retired beats the retire.
    pending_d = (pending_q & ~eret_clr) | edge_det;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      src_prev_q   <= '0;
      pending_q    <= '0;
      take_q       <= 1'b0;
      in_service_q <= 1'b0;
      vector_q     <= '0;
      cause_q      <= '0;
      active_id_q  <= '0;
    end else begin
      src_prev_q <= exp_src;
      pending_q  <= pending_d;
      unique case (state_q)
        StIdle: begin
          if (any_eligible && !exp_block) begin
            state_q      <= StTake;
            take_q       <= 1'b1;
            vector_q     <= HANDLER_ADDR;
            in_service_q <= 1'b1;
            active_id_q  <= winner;
            cause_q      <= winner_cause;
          end
        end
        StTake: begin
          state_q  <= StService;
          take_q   <= 1'b0;
          vector_q <= '0;
        end
        StService: begin
          if (is_eret) begin
            state_q      <= StIdle;
            in_service_q <= 1'b0;
            active_id_q  <= '0;
            cause_q      <= '0;
          end
        end
        default: begin
          state_q      <= StIdle;
          take_q       <= 1'b0;
          vector_q     <= '0;
          in_service_q <= 1'b0;
          active_id_q  <= '0;
          cause_q      <= '0;
        end
      endcase
    end
  end

  assign take       = take_q;
  assign vector     = vector_q;
  assign in_service = in_service_q;
  assign active_id  = active_id_q;
  assign cause      = cause_q;
  assign pending    = pending_q;

  take_one_cycle: assert property (@(posedge clk) disable iff (clr) take |=> !take);
  take_in_service: assert property (@(posedge clk) disable iff (clr) take |-> in_service);

endmodule
